// File: rtl/sm83_cb_pkg.sv
// Shared types for the SM83 CB-prefix sequencer: FSM states, opcode classes, operand decode.
package sm83_cb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WRITE,
    FIN
  } cb_state_t;

  typedef enum logic [1:0] {
    CB_ROT,
    CB_BIT,
    CB_RES,
    CB_SET
  } cb_class_t;

  localparam logic [2:0] REG_HL_IND = 3'd6;

  function automatic logic is_mem_operand(input logic [2:0] sel);
    return sel == REG_HL_IND;
  endfunction

endpackage

// File: rtl/sm83_cb_wait_timer.sv
// Memory-phase wait counter for the CB sequencer; expired_o flags the cycle the count would reach WAIT_MAX.
module sm83_cb_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [3:0] LAST = 4'(WAIT_MAX - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sm83_cb_sequencer.sv
// Multi-cycle sequencer for CB-prefixed SM83 instructions (rot/shift/SWAP, BIT, RES, SET).
// Define SM83_CB_MEM_TIMEOUT_EN to enable the memory-phase timeout and abort path.
module sm83_cb_sequencer
  import sm83_cb_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cb_op,
  input  logic       mem_ack,
  output logic       busy,
  output logic [2:0] alu_op543,
  output logic       alu_shift,
  output logic [1:0] alu_bitop,
  output logic [2:0] reg_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       flag_we,
  output logic       done,
  output logic       abort
);

  if (WAIT_MAX == 0 || WAIT_MAX > 15) begin : g_wait_max_bad
    $error("sm83_cb_sequencer: WAIT_MAX must be in 1..15");
  end

  cb_state_t state_q, state_d;
  logic [7:0] op_q, op_d;
  cb_class_t  cls;
  logic       mem_opnd;
  logic       tmo_expired;

  assign cls       = cb_class_t'(op_q[7:6]);
  assign mem_opnd  = is_mem_operand(op_q[2:0]);
  assign alu_op543 = op_q[5:3];
  assign alu_bitop = op_q[7:6];
  assign reg_sel   = op_q[2:0];

`ifdef SM83_CB_MEM_TIMEOUT_EN
  logic wait_active;

  assign wait_active = (state_q == READ) || (state_q == WRITE);

  sm83_cb_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (!wait_active || mem_ack),
    .en_i     (wait_active && !mem_ack),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    busy      = 1'b1;
    alu_shift = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_we    = 1'b0;
    flag_we   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          op_d    = cb_op;
          state_d = is_mem_operand(cb_op[2:0]) ? READ : EXEC;
        end
      end
      READ: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          state_d = EXEC;
        end else if (tmo_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      EXEC: begin
        alu_shift = (cls == CB_ROT);
        reg_we    = !mem_opnd && (cls != CB_BIT);
        state_d   = (mem_opnd && (cls != CB_BIT)) ? WRITE : FIN;
      end
      WRITE: begin
        mem_wr = 1'b1;
        if (mem_ack) begin
          state_d = FIN;
        end else if (tmo_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      FIN: begin
        // RES/SET leave flags untouched
        flag_we = (cls == CB_ROT) || (cls == CB_BIT);
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sm83_cb_sequencer.sv
// Self-checking bench for sm83_cb_sequencer: per-cycle phase model plus literal pins on pulse/cycle counts.
module tb_sm83_cb_sequencer;

  localparam int WAIT_MAX = 15;
`ifdef SM83_CB_MEM_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] cb_op;
  logic       mem_ack;
  logic       busy;
  logic [2:0] alu_op543;
  logic       alu_shift;
  logic [1:0] alu_bitop;
  logic [2:0] reg_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_we;
  logic       flag_we;
  logic       done;
  logic       abort;

  sm83_cb_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cb_op    (cb_op),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .alu_op543(alu_op543),
    .alu_shift(alu_shift),
    .alu_bitop(alu_bitop),
    .reg_sel  (reg_sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .reg_we   (reg_we),
    .flag_we  (flag_we),
    .done     (done),
    .abort    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_shift;
    logic       reg_we;
    logic       flag_we;
    logic       done;
    logic       abort;
    logic [2:0] op543;
    logic [1:0] bitop;
    logic [2:0] regsel;
  } outs_t;

  typedef struct {
    logic       start;
    logic [7:0] op_in;
    logic       ack;
    outs_t      exp;
  } step_t;

  step_t      plan[$];
  logic [7:0] m_op;
  int         checks, errors, stepno;
  int n_busy, n_rd, n_wr, n_shift, n_rwe, n_fwe, n_done, n_abort;

  function automatic outs_t base(input logic bsy, input logic [7:0] lat);
    outs_t o;
    o        = '0;
    o.busy   = bsy;
    o.op543  = lat[5:3];
    o.bitop  = lat[7:6];
    o.regsel = lat[2:0];
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.busy      = busy;
    o.mem_rd    = mem_rd;
    o.mem_wr    = mem_wr;
    o.alu_shift = alu_shift;
    o.reg_we    = reg_we;
    o.flag_we   = flag_we;
    o.done      = done;
    o.abort     = abort;
    o.op543     = alu_op543;
    o.bitop     = alu_bitop;
    o.regsel    = reg_sel;
    return o;
  endfunction

  task automatic push(input logic st, input logic [7:0] opi, input logic ack, input outs_t e);
    step_t s;
    s.start = st;
    s.op_in = opi;
    s.ack   = ack;
    s.exp   = e;
    plan.push_back(s);
  endtask

  // One memory phase: ack arrives after `waits` idle cycles unless the timeout fires first.
  task automatic mem_phase(input logic [7:0] op, input int waits, input logic wr,
                           input logic noise, output logic aborted);
    outs_t e;
    aborted = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      e = base(1'b1, op);
      if (wr) e.mem_wr = 1'b1;
      else    e.mem_rd = 1'b1;
      if (TMO && i != waits && i == WAIT_MAX - 1) begin
        e.abort = 1'b1;
        push(noise, ~op, 1'b0, e);
        aborted = 1'b1;
        break;
      end
      push(noise, ~op, (i == waits), e);
    end
  endtask

  task automatic build(input logic [7:0] op, input int w_r, input int w_w, input logic noise);
    logic  mem, ab;
    logic [1:0] cls;
    outs_t e;
    mem = (op[2:0] == 3'd6);
    cls = op[7:6];
    push(1'b1, op, noise, base(1'b0, m_op));
    m_op = op;
    if (mem) begin
      mem_phase(op, w_r, 1'b0, noise, ab);
      if (ab) return;
    end
    e           = base(1'b1, op);
    e.alu_shift = (cls == 2'd0);
    e.reg_we    = !mem && (cls != 2'd1);
    push(noise, ~op, noise, e);
    if (mem && cls != 2'd1) begin
      mem_phase(op, w_w, 1'b1, noise, ab);
      if (ab) return;
    end
    e         = base(1'b1, op);
    e.flag_we = (cls <= 2'd1);
    e.done    = 1'b1;
    push(noise, ~op, noise, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 8'h00, 1'b0, base(1'b0, m_op));
  endtask

  task automatic clr_mon();
    n_busy = 0; n_rd = 0; n_wr = 0; n_shift = 0;
    n_rwe = 0; n_fwe = 0; n_done = 0; n_abort = 0;
  endtask

  task automatic run(input int n);
    step_t s;
    outs_t got;
    for (int k = 0; k < n && plan.size() > 0; k++) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      start   = s.start;
      cb_op   = s.op_in;
      mem_ack = s.ack;
      @(negedge clk);
      got = sample();
      checks++;
      stepno++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL cycle_outputs step=%0d got=%05h exp=%05h", stepno, got, s.exp);
      end
      n_busy  += int'(got.busy);
      n_rd    += int'(got.mem_rd);
      n_wr    += int'(got.mem_wr);
      n_shift += int'(got.alu_shift);
      n_rwe   += int'(got.reg_we);
      n_fwe   += int'(got.flag_we);
      n_done  += int'(got.done);
      n_abort += int'(got.abort);
    end
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic run_all();
    run(plan.size());
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0; stepno = 0;
    reset = 1'b1; start = 1'b0; cb_op = 8'h00; mem_ack = 1'b0; m_op = 8'h00;
    clr_mon();

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", int'(sample()), 0);
    reset = 1'b0;
    idle(2);
    run_all();

    // RLC B
    clr_mon(); build(8'h00, 0, 0, 1'b0); run_all();
    check("rlc_b_busy_cycles", n_busy, 2);
    check("rlc_b_reg_we", n_rwe, 1);
    check("rlc_b_flag_we", n_fwe, 1);
    check("rlc_b_done", n_done, 1);

    // SRL (HL), immediate acks
    idle(1);
    clr_mon(); build(8'h3E, 0, 0, 1'b0); run_all();
    check("srl_hl_busy_cycles", n_busy, 4);
    check("srl_hl_mem_rd", n_rd, 1);
    check("srl_hl_mem_wr", n_wr, 1);
    check("srl_hl_shift", n_shift, 1);

    // BIT 0,(HL), read ack after 3 waits
    idle(1);
    clr_mon(); build(8'h46, 3, 0, 1'b0); run_all();
    check("bit_hl_busy_cycles", n_busy, 6);
    check("bit_hl_mem_rd", n_rd, 4);
    check("bit_hl_mem_wr", n_wr, 0);
    check("bit_hl_reg_we", n_rwe, 0);
    check("bit_hl_flag_we", n_fwe, 1);

    // SET 0,A back-to-back with the previous done
    clr_mon(); build(8'hC7, 0, 0, 1'b0); run_all();
    check("set_a_reg_we", n_rwe, 1);
    check("set_a_shift", n_shift, 0);
    check("set_a_flag_we", n_fwe, 0);
    check("set_a_done", n_done, 1);

    // Spurious start/ack while busy, memory RES and register BIT/SWAP
    idle(1);
    build(8'h86, 2, 1, 1'b1);
    build(8'h7D, 0, 0, 1'b1);
    build(8'h37, 0, 0, 1'b1);
    idle(1);
    clr_mon(); run_all();
    check("noise_done", n_done, 3);

    // Ack on the last permitted wait cycle of both phases
    clr_mon(); build(8'hFE, WAIT_MAX - 1, WAIT_MAX - 1, 1'b0); idle(1); run_all();
    check("ack_wins_abort", n_abort, 0);
    check("ack_wins_done", n_done, 1);

    // Read never acked for 40 cycles
    clr_mon(); build(8'h06, 40, 0, 1'b0); idle(2); run_all();
`ifdef SM83_CB_MEM_TIMEOUT_EN
    check("timeout_abort", n_abort, 1);
    check("timeout_done", n_done, 0);
    check("timeout_busy_cycles", n_busy, 15);
`else
    check("no_timeout_abort", n_abort, 0);
    check("no_timeout_done", n_done, 1);
    check("no_timeout_busy_cycles", n_busy, 44);
`endif

    // Reset asserted in the middle of a stalled write
    build(8'h0E, 0, 50, 1'b0);
    run(5);
    plan.delete();
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_mem_wr", int'(mem_wr), 0);
    check("arst_fields", int'({alu_op543, alu_bitop, reg_sel}), 0);
    check("arst_outputs", int'(sample()), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    m_op  = 8'h00;

    // Recovery: SLA (HL)
    clr_mon(); idle(2); build(8'h26, 1, 2, 1'b0); idle(1); run_all();
    check("recover_done", n_done, 1);
    check("recover_mem_wr", n_wr, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm83_cb_sequencer.md
Name: sm83_cb_sequencer

Overview:
Multi-cycle sequencer for CB-prefixed SM83 instructions: rotate/shift/SWAP, BIT, RES and SET.
- Decodes the latched CB opcode byte and drives the ALU control inputs: op543, shift, and flag/writeback strobes.
- Runs the memory read/write phases for the (HL) operand (op[2:0]==6).
- Sits between the instruction decoder (start/opcode) and the ALU control, register file and memory bus.

Parameters:
WAIT_MAX, 15, max cycles a memory phase waits for mem_ack before aborting (4-bit counter; legal range 1..15).

Ports:
clk  input  1  core clock, all state on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
cb_op  input  8  CB opcode byte; latched on accepted start
mem_ack  input  1  memory handshake: read data valid / write accepted
busy  output  1  high in every state except IDLE
alu_op543  output  3  latched cb_op[5:3], fed to ALU control op543
alu_shift  output  1  shift strobe to ALU control (rotate/shift class only)
alu_bitop  output  2  latched cb_op[7:6]: 0=rot/shift, 1=BIT, 2=RES, 3=SET
reg_sel  output  3  latched cb_op[2:0]
mem_rd  output  1  memory read request, level, held until mem_ack
mem_wr  output  1  memory write request, level, held until mem_ack
reg_we  output  1  one-cycle register writeback strobe
flag_we  output  1  one-cycle flag-register update strobe
done  output  1  one-cycle completion pulse
abort  output  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (async): state=IDLE, wait counter=0, all outputs 0, latched opcode=0.
- States: IDLE, READ, EXEC, WRITE, FIN.
- IDLE:
  - On start, latch cb_op.
  - mem = (cb_op[2:0]==6). Go to READ if mem, else EXEC.
  - start outside IDLE is ignored; no queueing.
- READ: mem_rd=1.
  - On mem_ack, go to EXEC and clear the counter.
  - Otherwise increment the counter. When the counter reaches WAIT_MAX without ack: abort pulse, go to IDLE.
- EXEC (exactly 1 cycle):
  - alu_shift=1 iff alu_bitop==0.
  - Register operand: reg_we=1 unless BIT.
  - Next state is WRITE if mem and not BIT, else FIN.
- WRITE: mem_wr=1. Same ack/timeout rule as READ; on ack go to FIN.
- FIN (1 cycle):
  - flag_we=1 for rot/shift and BIT; flag_we=0 for RES/SET.
  - done=1, then go to IDLE.
- Latency, start to done pulse:
  - Register operand: 3 cycles (IDLE→EXEC→FIN).
  - Memory BIT: 3+read waits.
  - Memory rot/RES/SET: 4+read waits+write waits.
- Other rules:
  - busy deasserts the cycle after done or abort. A start in that IDLE cycle is accepted (back-to-back).
  - mem_ack in a non-memory state is ignored.
  - mem_ack on the same cycle the counter would hit WAIT_MAX: ack wins, no abort.
  - Reset mid-operation: immediate IDLE, no done, no abort, no writes.
  - alu_op543/alu_bitop/reg_sel hold the latched value while busy and retain it in IDLE.

Optional Feature:
SM83_CB_MEM_TIMEOUT_EN
- Defined: wait counter and abort path as above.
- Undefined: memory phases wait indefinitely for mem_ack. abort is tied 0, the counter is not instantiated, and WAIT_MAX is unused.

Decomposition:
- Package sm83_cb_pkg:
  - typedef enum logic [2:0] cb_state_t {IDLE, READ, EXEC, WRITE, FIN}.
  - typedef enum logic [1:0] cb_class_t {CB_ROT, CB_BIT, CB_RES, CB_SET}.
  - localparam REG_HL_IND = 3'd6.
- Sub-module: sm83_cb_wait_timer (counter, clear/enable, expired flag), instantiated only under the macro.

Test Plan:
- Register op: start with cb_op=0x00 (RLC B):
  - Cycle+1: alu_shift=1, reg_we=1, alu_op543=0.
  - Cycle+2: flag_we=1, done=1; busy low after that.
- Memory op, no waits: cb_op=0x3E (SRL (HL)), mem_ack immediate:
  - mem_rd for 1 cycle, EXEC with alu_shift=1 and alu_op543=7, mem_wr for 1 cycle.
  - FIN: flag_we=1, done=1. Total 4 cycles.
- Memory BIT: cb_op=0x46 (BIT 0,(HL)) with mem_ack delayed 3 cycles:
  - mem_rd held 4 cycles, no mem_wr, no reg_we.
  - flag_we=1, done at cycle 6.
- RES/SET: cb_op=0xC7 (SET 0,A):
  - reg_we=1, alu_shift=0, flag_we=0 in FIN, done=1.
- Timeout (macro on, WAIT_MAX=15): cb_op=0x06, mem_ack never asserted:
  - abort pulses after 15 READ cycles, done never pulses, busy drops.
  - Macro off: busy stays high indefinitely.
- Robustness:
  - start asserted while busy → ignored.
  - reset asserted during WRITE → all outputs 0 immediately, state IDLE.
  - New start on the cycle after done → accepted.
